pwm_output_stage: RTL and testbench
===================================

// Module: pwm_output_stage
//
// PURPOSE
// - Consumes the five configuration bytes written over SPI (output enables, PWM enables, duty cycle).
// - Drives 16 output pins with one of three values: forced low, static high, or a shared 8-bit PWM waveform.
// - Sits directly downstream of the SPI register file. All inputs are registered values in the clk domain.
// - Single shared PWM counter for all 16 channels. Period is 256 ticks; a tick is PRESCALE clk cycles.
//
// PARAMETERS
// - PRESCALE   13   clk cycles per PWM tick; legal range >=1. 10 MHz / (13*256) = ~3.0 kHz.
// - PRE_W      16   prescaler counter width; must hold PRESCALE-1.
//
// PORTS
// - clk                  in   1   system clock; the only clock.
// - nrst                 in   1   reset; synchronous, active-low.
// - en_reg_7_0           in   8   output enable, channels 7..0.
// - en_reg_15_8          in   8   output enable, channels 15..8.
// - en_pwm_7_0           in   8   PWM mode select, channels 7..0.
// - en_pwm_15_8          in   8   PWM mode select, channels 15..8.
// - pwm_duty_cycle       in   8   shared duty: high ticks per 256-tick period; 0xFF means 100%.
// - out                  out  16  channel outputs, registered.
// - pwm_level            out  1   raw shared PWM level, registered.
// - period_start         out  1   one-cycle pulse in the first clk cycle of each PWM period.
//
// BEHAVIOUR
// - Reset (nrst low at a clk edge): pre_cnt=0, pwm_cnt=0, out=0, pwm_level=0, period_start=0.
//   - duty_act=0 and the shadow enables = 0.
//   - Asserting reset mid-period aborts the period.
//   - The first cycle after release counts pre_cnt 0->1; the first period starts with pwm_cnt=0.
// - Prescaler:
//   - pre_cnt counts 0..PRESCALE-1 and then wraps.
//   - tick = (pre_cnt==PRESCALE-1).
//   - PRESCALE=1 gives a tick every cycle.
// - Counter:
//   - pwm_cnt advances by 1 on each tick; 8-bit wrap 255->0.
//   - Between ticks, pwm_cnt holds.
// - Boundary:
//   - wrap = tick && pwm_cnt==255.
//   - period_start is registered: it is high for exactly the one cycle after wrap, i.e. the first cycle with pwm_cnt==0.
// - Level, computed from the current pwm_cnt and registered, so it has 1-cycle latency:
//   - pwm_level <= (duty_act==8'hFF) ? 1 : (pwm_cnt < duty_act).
//   - duty 0x00 gives constant low.
//   - duty 0xFF gives constant high; 255/256 is not a legal result.
// - Channel mux, per bit i, registered, 1-cycle latency from the inputs:
//   - out[i] <= !en_reg[i] ? 0 : (!en_pwm_act[i] ? 1 : pwm_lvl_comb).
//   - pwm_lvl_comb is the pre-register term of pwm_level, so out and pwm_level align on the same cycle.
//   - en_reg has priority: en_reg=0 forces low regardless of en_pwm.
// - Simultaneous events:
//   - An input change on the same cycle as wrap is captured by that wrap (see CONFIGURATION).
//   - A reset on the same cycle as wrap wins; no period_start pulse is produced.
// - Input changes: en_reg takes effect on the next clk edge with no gating.
//
// CONFIGURATION
// - PWM_SYNC_UPDATE_EN defined:
//   - duty_act and en_pwm_act are shadow registers.
//   - They load pwm_duty_cycle / en_pwm_* only on wrap.
//   - The running period always completes with its old duty and mode, so there are no partial pulses.
//   - After reset the shadows are 0 until the first wrap, so every channel is static high or low.
// - PWM_SYNC_UPDATE_EN undefined:
//   - duty_act = pwm_duty_cycle and en_pwm_act = en_pwm_* as combinational passthroughs.
//   - Changes reach out after 1 cycle, mid-period included.
//
// TESTING
// 1. Reset hold:
//    - Stimulus: nrst=0 for 5 clks with all config inputs = 0xFF.
//    - Required: out=0, pwm_level=0, period_start=0. After release, pwm_cnt starts at 0.
// 2. Static mode:
//    - Stimulus: en_reg_7_0=0x01, en_pwm_7_0=0x00.
//    - Required: out==16'h0001 one clk later and constant thereafter.
//    - Then set en_reg_7_0=0x00: out==0 one clk later.
// 3. Half duty:
//    - Stimulus: PRESCALE=1, en_reg_15_8=en_pwm_15_8=0x80, duty=0x80 (with the macro, wait for one wrap first).
//    - Required: out[15] high for 128 clks, then low for 128 clks; period 256 clks.
// 4. Extremes:
//    - Stimulus: duty=0x00 over 2 periods. Required: out[i] never high.
//    - Stimulus: duty=0xFF over 2 periods. Required: never low, not even at pwm_cnt=255.
// 5. Duty change mid-period, PRESCALE=1, change 0x40->0xC0 at pwm_cnt=100:
//    - With PWM_SYNC_UPDATE_EN: this period shows 64 high clks, the next shows 192.
//    - Without the macro: out goes high again 1 clk after the change.
// 6. Period strobe:
//    - Stimulus: PRESCALE=13.
//    - Required: period_start is 1 clk wide, every 3328 clks.
//    - A reset mid-period suppresses the pending pulse and restarts the count.

Source files
------------

// File: rtl/pwm_output_stage.sv
// pwm_output_stage: one shared 8-bit PWM counter driving 16 pins (forced low / static high / PWM).
// Build option PWM_SYNC_UPDATE_EN: duty and PWM mode are shadowed and only reload at period wrap.

module pwm_lane (
  input  logic clk,
  input  logic nrst,
  input  logic en_reg_i,
  input  logic en_pwm_i,
  input  logic lvl_i,
  output logic out_o
);
  logic out_q, out_d;

  // en_reg dominates: a disabled pin is low whatever its mode.
  always_comb out_d = en_reg_i & (~en_pwm_i | lvl_i);

  always_ff @(posedge clk) begin
    if (!nrst) out_q <= 1'b0;
    else       out_q <= out_d;
  end

  assign out_o = out_q;
endmodule

module pwm_output_stage #(
  parameter int PRESCALE = 13,
  parameter int PRE_W    = 16
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  en_reg_7_0,
  input  logic [7:0]  en_reg_15_8,
  input  logic [7:0]  en_pwm_7_0,
  input  logic [7:0]  en_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        pwm_level,
  output logic        period_start
);
  localparam int NUM_LANES = 16;

  logic [PRE_W-1:0]     pre_cnt_q, pre_cnt_d;
  logic [7:0]           pwm_cnt_q, pwm_cnt_d;
  logic                 pwm_level_q, period_start_q;
  logic                 tick, wrap, pwm_lvl_comb;
  logic [7:0]           duty_act;
  logic [NUM_LANES-1:0] en_pwm_act, en_reg, lane_out;

  assign en_reg = {en_reg_15_8, en_reg_7_0};
  assign tick   = (pre_cnt_q == PRE_W'(PRESCALE - 1));
  assign wrap   = tick && (pwm_cnt_q == 8'hFF);

  always_comb begin
    pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // 0xFF is special-cased so full duty is truly 100% rather than 255/256.
  assign pwm_lvl_comb = (duty_act == 8'hFF) | (pwm_cnt_q < duty_act);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      pwm_level_q    <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      pwm_level_q    <= pwm_lvl_comb;
      period_start_q <= wrap;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  logic [7:0]           duty_act_q, duty_act_d;
  logic [NUM_LANES-1:0] en_pwm_act_q, en_pwm_act_d;

  // Shadows reload only at the wrap so a running period never sees a partial update.
  always_comb begin
    duty_act_d   = duty_act_q;
    en_pwm_act_d = en_pwm_act_q;
    if (wrap) begin
      duty_act_d   = pwm_duty_cycle;
      en_pwm_act_d = {en_pwm_15_8, en_pwm_7_0};
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      duty_act_q   <= '0;
      en_pwm_act_q <= '0;
    end else begin
      duty_act_q   <= duty_act_d;
      en_pwm_act_q <= en_pwm_act_d;
    end
  end

  assign duty_act   = duty_act_q;
  assign en_pwm_act = en_pwm_act_q;
`else
  assign duty_act   = pwm_duty_cycle;
  assign en_pwm_act = {en_pwm_15_8, en_pwm_7_0};
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    pwm_lane u_lane (
      .clk      (clk),
      .nrst     (nrst),
      .en_reg_i (en_reg[i]),
      .en_pwm_i (en_pwm_act[i]),
      .lvl_i    (pwm_lvl_comb),
      .out_o    (lane_out[i])
    );
  end

  assign out          = lane_out;
  assign pwm_level    = pwm_level_q;
  assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_output_stage.sv
// Randomized + directed bench for pwm_output_stage; two instances (PRESCALE 13 and 1) share stimulus.
`timescale 1ns/1ps
module tb_pwm_output_stage;
  logic clk = 1'b0, nrst = 1'b0;
  logic [7:0] er_lo, er_hi, ep_lo, ep_hi, duty;
  logic [15:0] out13, out1;
  logic lvl13, lvl1, ps13, ps1;
  bit mon_en = 1'b0;
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  pwm_output_stage #(.PRESCALE(13), .PRE_W(16)) u_dut13 (
    .clk(clk), .nrst(nrst), .en_reg_7_0(er_lo), .en_reg_15_8(er_hi),
    .en_pwm_7_0(ep_lo), .en_pwm_15_8(ep_hi), .pwm_duty_cycle(duty),
    .out(out13), .pwm_level(lvl13), .period_start(ps13));

  pwm_output_stage #(.PRESCALE(1), .PRE_W(16)) u_dut1 (
    .clk(clk), .nrst(nrst), .en_reg_7_0(er_lo), .en_reg_15_8(er_hi),
    .en_pwm_7_0(ep_lo), .en_pwm_15_8(ep_hi), .pwm_duty_cycle(duty),
    .out(out1), .pwm_level(lvl1), .period_start(ps1));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: n = clk edges since reset release; pwm_cnt = (n / PRESCALE) mod 256.
  int          mn[2];
  logic [15:0] mout[2], menp[2];
  logic        mlvl[2], mps[2];
  logic [7:0]  mduty[2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      automatic int p = (k == 0) ? 13 : 1;
      automatic int cnt, n1;
      automatic logic [7:0] d;
      automatic logic [15:0] ep, er;
      automatic logic lv;
      automatic bit wr;
      if (!nrst) begin
        mn[k] <= 0; mout[k] <= '0; mlvl[k] <= 1'b0; mps[k] <= 1'b0;
        mduty[k] <= '0; menp[k] <= '0;
      end else begin
        cnt = (mn[k] / p) % 256;
`ifdef PWM_SYNC_UPDATE_EN
        d = mduty[k]; ep = menp[k];
`else
        d = duty; ep = {ep_hi, ep_lo};
`endif
        er = {er_hi, er_lo};
        lv = (d == 8'hFF) || (cnt < int'(d));
        mlvl[k] <= lv;
        mout[k] <= er & (~ep | {16{lv}});
        n1 = mn[k] + 1;
        wr = (n1 % (256 * p)) == 0;
        mps[k] <= wr;
        if (wr) begin mduty[k] <= duty; menp[k] <= {ep_hi, ep_lo}; end
        mn[k] <= n1;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out13", {16'h0, out13}, {16'h0, mout[0]});
      chk("lvl13", {31'h0, lvl13}, {31'h0, mlvl[0]});
      chk("ps13",  {31'h0, ps13},  {31'h0, mps[0]});
      chk("out1",  {16'h0, out1},  {16'h0, mout[1]});
      chk("lvl1",  {31'h0, lvl1},  {31'h0, mlvl[1]});
      chk("ps1",   {31'h0, ps1},   {31'h0, mps[1]});
    end
  end

  task automatic wait_ps1();
    int c = 0;
    while (!ps1 && c < 600) begin @(negedge clk); c++; end
    if (!ps1) chk("wait_ps1_timeout", 32'(c), 32'd0);
  endtask

  task automatic run_len(input logic val, output int len);
    len = 0;
    while (out1[15] === val && len < 1000) begin @(negedge clk); len++; end
  endtask

  task automatic cnt_to_ps13(input string tag);
    int c = 0;
    while (!ps13 && c < 5000) begin @(negedge clk); c++; end
    chk(tag, 32'(c), 32'd3328);
  endtask

  initial begin
    int c, hi, lo;
    {er_lo, er_hi, ep_lo, ep_hi, duty} = {5{8'hFF}};
    nrst = 1'b0;
    @(negedge clk); mon_en = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_out13", {16'h0, out13}, 32'h0);
    chk("rst_out1",  {16'h0, out1},  32'h0);
    chk("rst_lvl1",  {31'h0, lvl1},  32'h0);
    chk("rst_ps13",  {31'h0, ps13},  32'h0);

    // First period after release starts at pwm_cnt=0: first strobe after exactly 256 clks.
    nrst = 1'b1;
    c = 0;
    while (!ps1 && c < 1000) begin @(negedge clk); c++; end
    chk("first_period1", 32'(c), 32'd256);

    // Static mode
    {er_hi, ep_hi, ep_lo} = '0; er_lo = 8'h01;
    @(negedge clk);
    chk("static_on1", {16'h0, out1}, 32'h0001);
    chk("static_on13", {16'h0, out13}, 32'h0001);
    hi = 0;
    repeat (20) begin @(negedge clk); if (out1 !== 16'h0001) hi++; end
    chk("static_hold", 32'(hi), 32'd0);
    er_lo = 8'h00;
    @(negedge clk);
    chk("static_off1", {16'h0, out1}, 32'h0);

    // Half duty on channel 15
    er_hi = 8'h80; ep_hi = 8'h80; duty = 8'h80;
    wait_ps1();
    c = 0;
    while (out1[15] !== 1'b1 && c < 600) begin @(negedge clk); c++; end
    run_len(1'b1, hi);
    run_len(1'b0, lo);
    chk("half_high", 32'(hi), 32'd128);
    chk("half_low",  32'(lo), 32'd128);

    // Extremes
    {er_lo, er_hi, ep_lo, ep_hi} = {4{8'hFF}}; duty = 8'h00;
    @(negedge clk); wait_ps1();
    hi = 0;
    repeat (512) begin @(negedge clk); if (out1 !== 16'h0) hi++; end
    chk("duty00_high", 32'(hi), 32'd0);
    duty = 8'hFF;
    @(negedge clk); wait_ps1();
    lo = 0;
    repeat (512) begin @(negedge clk); if (out1 !== 16'hFFFF) lo++; end
    chk("dutyFF_low", 32'(lo), 32'd0);

    // Duty change 0x40 -> 0xC0 at pwm_cnt=100
    duty = 8'h40;
    @(negedge clk); wait_ps1();
    @(negedge clk); wait_ps1();
    repeat (100) @(negedge clk);
    chk("mid_pre", {31'h0, out1[15]}, 32'h0);
    duty = 8'hC0;
    @(negedge clk);
`ifdef PWM_SYNC_UPDATE_EN
    chk("mid_post", {31'h0, out1[15]}, 32'h0);
`else
    chk("mid_post", {31'h0, out1[15]}, 32'h1);
`endif
    wait_ps1();
    hi = 0;
    repeat (256) begin @(negedge clk); if (out1[15] === 1'b1) hi++; end
    chk("next_period_high", 32'(hi), 32'd192);

    // Period strobe at PRESCALE=13
    c = 0;
    while (!ps13 && c < 4000) begin @(negedge clk); c++; end
    @(negedge clk);
    chk("ps13_width", {31'h0, ps13}, 32'h0);
    c = 1;
    while (!ps13 && c < 5000) begin @(negedge clk); c++; end
    chk("ps13_interval", 32'(c), 32'd3328);
    repeat (1000) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk("midrst_ps13", {31'h0, ps13}, 32'h0);
    chk("midrst_out13", {16'h0, out13}, 32'h0);
    @(negedge clk);
    nrst = 1'b1;
    cnt_to_ps13("ps13_after_rst");

    // Reset on the wrap cycle: no strobe
    @(negedge clk); wait_ps1();
    repeat (255) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    chk("rst_on_wrap_ps1", {31'h0, ps1}, 32'h0);
    nrst = 1'b1;

    // Randomized configuration with occasional resets
    repeat (60) begin
      int r;
      er_lo = 8'($urandom); er_hi = 8'($urandom);
      ep_lo = 8'($urandom); ep_hi = 8'($urandom);
      r = $urandom_range(0, 9);
      duty = (r == 0) ? 8'h00 : (r == 1) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 14) == 0) begin
        nrst = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        nrst = 1'b1;
      end
      repeat ($urandom_range(1, 400)) @(negedge clk);
    end

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
